serial_parity_checker: RTL and testbench

//   Receive end of the XOR-parity serial link: deserialises a DATA_W-bit frame sent
//   LSB-first plus one trailing parity bit, and recomputes parity with a running XOR.

---
 rtl/serial_parity_checker_if.sv | 24 ++
 rtl/serial_parity_checker.sv | 126 ++++++++++++
 tb/tb_serial_parity_checker.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_parity_checker_if.sv
// Serial-link bundle between the line sampler (master) and the parity checker (slave).
// The master drives the bit stream; the slave returns the completed word and status.
interface serial_parity_checker_if #(
    parameter int unsigned DATA_W = 8
);
    logic              in_valid;
    logic              in_sof;
    logic              in_bit;
    logic [DATA_W-1:0] data_out;
    logic              out_valid;
    logic              parity_err;
    logic              abort;
    logic              busy;

    modport master (
        output in_valid, in_sof, in_bit,
        input  data_out, out_valid, parity_err, abort, busy
    );

    modport slave (
        input  in_valid, in_sof, in_bit,
        output data_out, out_valid, parity_err, abort, busy
    );
endinterface

// File: rtl/serial_parity_checker.sv
// Receive end of the XOR-parity serial link: deserialises an LSB-first frame plus a
// trailing parity bit and reports the word with a one-cycle valid pulse and error flag.
module serial_parity_checker #(
    parameter int unsigned DATA_W = 8,
    parameter bit          ODD    = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    serial_parity_checker_if.slave link
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] shift;
    logic [DATA_W-1:0] data_q;
    logic [CNT_W-1:0]  count;
    logic              acc;
    logic              out_valid_q;
    logic              parity_err_q;
    logic              abort_q;

    logic              start;
    logic              take;
    logic              finish;
    logic              restart;
    logic              busy_int;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a start-of-frame bit restarts from any state
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (link.in_valid && link.in_sof) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (link.in_valid && !link.in_sof && (count == CNT_W'(DATA_W - 1))) begin
                    state_next = PAR;
                end
            end
            PAR: begin
                if (link.in_valid) begin
                    state_next = link.in_sof ? DATA : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath strobes and busy status decoded from the current state
    always_comb begin
        start    = 1'b0;
        take     = 1'b0;
        finish   = 1'b0;
        restart  = 1'b0;
        busy_int = (state != IDLE);
        if (link.in_valid) begin
            if (link.in_sof) begin
                start   = 1'b1;
                restart = (state != IDLE);
            end else begin
                take   = (state == DATA);
                finish = (state == PAR);
            end
        end
    end

    // Shift register, running parity and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift        <= '0;
            data_q       <= '0;
            count        <= '0;
            acc          <= 1'b0;
            out_valid_q  <= 1'b0;
            parity_err_q <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            out_valid_q <= finish;
            abort_q     <= restart;
            if (start) begin
                shift[0] <= link.in_bit;
                acc      <= link.in_bit;
                count    <= CNT_W'(1);
            end else if (take) begin
                for (int i = 0; i < DATA_W; i++) begin
                    if (count == CNT_W'(i)) begin
                        shift[i] <= link.in_bit;
                    end
                end
                acc   <= acc ^ link.in_bit;
                count <= count + CNT_W'(1);
            end else if (finish) begin
                data_q       <= shift;
                parity_err_q <= acc ^ link.in_bit ^ ODD;
                count        <= '0;
                acc          <= 1'b0;
            end
        end
    end

    assign link.data_out   = data_q;
    assign link.out_valid  = out_valid_q;
    assign link.parity_err = parity_err_q;
    assign link.abort      = abort_q;
    assign link.busy       = busy_int;

endmodule

// File: tb/tb_serial_parity_checker.sv
// Self-checking bench: an even-parity and an odd-parity checker fed the same stream,
// with expectations derived from the frame contents sent.
`timescale 1ns/1ps
module tb_serial_parity_checker;

    logic clk;
    logic rst_n;
    int   passed;
    int   total;
    int   cyc;
    int   ov_cnt;
    int   ov_cnt1;
    int   ab_cnt;
    int   last_ov_cyc;

    serial_parity_checker_if #(.DATA_W(8)) if0 ();
    serial_parity_checker_if #(.DATA_W(8)) if1 ();

    assign if1.in_valid = if0.in_valid;
    assign if1.in_sof   = if0.in_sof;
    assign if1.in_bit   = if0.in_bit;

    serial_parity_checker #(.DATA_W(8), .ODD(1'b0)) dut_even (
        .clk   (clk),
        .rst_n (rst_n),
        .link  (if0)
    );

    serial_parity_checker #(.DATA_W(8), .ODD(1'b1)) dut_odd (
        .clk   (clk),
        .rst_n (rst_n),
        .link  (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Drive one cycle of the serial line and tally the pulses seen after the edge
    task automatic drive_bit(input bit v, input bit s, input bit b);
        @(negedge clk);
        if0.in_valid = v;
        if0.in_sof   = s;
        if0.in_bit   = b;
        @(posedge clk);
        #1;
        cyc++;
        if (if0.out_valid === 1'b1) begin
            ov_cnt++;
            last_ov_cyc = cyc;
        end
        if (if1.out_valid === 1'b1) ov_cnt1++;
        if (if0.abort === 1'b1) ab_cnt++;
    endtask

    // Send the data bits of a word (sof on bit 0), with idle cycles between bits
    task automatic send_data(input logic [7:0] w, input int fixed_gaps, input int rand_pct);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                for (int g = 0; g < fixed_gaps; g++) drive_bit(1'b0, 1'b0, 1'($urandom));
                while (int'($urandom_range(99)) < rand_pct) drive_bit(1'b0, 1'b0, 1'($urandom));
            end
            drive_bit(1'b1, (i == 0), w[i]);
        end
    endtask

    function automatic bit exp_err(input logic [7:0] w, input bit p, input bit odd);
        return (^w) ^ p ^ odd;
    endfunction

    task automatic clear_counts();
        ov_cnt  = 0;
        ov_cnt1 = 0;
        ab_cnt  = 0;
    endtask

    task automatic test_reset();
        if0.in_valid = 1'b0;
        if0.in_sof   = 1'b0;
        if0.in_bit   = 1'b0;
        rst_n        = 1'b0;
        #23;
        total++;
        if ({if0.data_out, if0.out_valid, if0.parity_err, if0.abort, if0.busy} !== 12'h000) begin
            $display("FAIL reset_outputs: got data=%h ov=%b pe=%b ab=%b busy=%b, want all 0",
                     if0.data_out, if0.out_valid, if0.parity_err, if0.abort, if0.busy);
        end else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        drive_bit(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_basic();
        // 0xA5 with even parity, then 0x01 which is wrong for even and right for odd
        logic [7:0] w;
        for (int k = 0; k < 2; k++) begin
            w = (k == 0) ? 8'hA5 : 8'h01;
            clear_counts();
            send_data(w, 0, 0);
            total++;
            if (if0.busy !== 1'b1 || ov_cnt != 0) begin
                $display("FAIL basic_busy_%0d: busy=%b ov=%0d, want busy=1 ov=0", k, if0.busy, ov_cnt);
            end else passed++;
            drive_bit(1'b1, 1'b0, 1'b0);
            total++;
            if (if0.out_valid !== 1'b1 || if0.data_out !== w || if0.busy !== 1'b0) begin
                $display("FAIL basic_word_%0d: ov=%b data=%h busy=%b, want ov=1 data=%h busy=0",
                         k, if0.out_valid, if0.data_out, if0.busy, w);
            end else passed++;
            total++;
            if (if0.parity_err !== exp_err(w, 1'b0, 1'b0) || if1.parity_err !== exp_err(w, 1'b0, 1'b1)) begin
                $display("FAIL basic_parity_%0d: even=%b odd=%b, want even=%b odd=%b", k,
                         if0.parity_err, if1.parity_err, exp_err(w, 1'b0, 1'b0), exp_err(w, 1'b0, 1'b1));
            end else passed++;
            drive_bit(1'b0, 1'b0, 1'b0);
            total++;
            if (if0.out_valid !== 1'b0 || ov_cnt != 1 || if0.data_out !== w) begin
                $display("FAIL basic_pulse_%0d: ov=%b count=%0d data=%h, want ov=0 count=1 data=%h",
                         k, if0.out_valid, ov_cnt, if0.data_out, w);
            end else passed++;
        end
    endtask

    task automatic test_gaps();
        logic [7:0] hold;
        hold = if0.data_out;
        clear_counts();
        send_data(8'hFF, 1, 0);
        drive_bit(1'b0, 1'b0, 1'b1);
        total++;
        if (ov_cnt != 0 || if0.data_out !== hold || if0.busy !== 1'b1) begin
            $display("FAIL gaps_hold: ov=%0d data=%h busy=%b, want ov=0 data=%h busy=1",
                     ov_cnt, if0.data_out, if0.busy, hold);
        end else passed++;
        drive_bit(1'b1, 1'b0, 1'b0);
        drive_bit(1'b0, 1'b0, 1'b1);
        drive_bit(1'b0, 1'b0, 1'b0);
        total++;
        if (ov_cnt != 1 || if0.data_out !== 8'hFF || if0.parity_err !== 1'b0) begin
            $display("FAIL gaps_word: ov=%0d data=%h pe=%b, want ov=1 data=ff pe=0",
                     ov_cnt, if0.data_out, if0.parity_err);
        end else passed++;
    endtask

    task automatic test_restart();
        logic [7:0] partial;
        partial = 8'h3C;
        clear_counts();
        for (int i = 0; i < 4; i++) drive_bit(1'b1, (i == 0), partial[i]);
        drive_bit(1'b1, 1'b1, 1'b0);
        total++;
        if (if0.abort !== 1'b1 || ab_cnt != 1) begin
            $display("FAIL restart_abort: abort=%b count=%0d, want abort=1 count=1", if0.abort, ab_cnt);
        end else passed++;
        // Remaining bits of 0x5A (bit 0 already sent as the restart bit)
        for (int i = 1; i < 8; i++) drive_bit(1'b1, 1'b0, 1'((8'h5A >> i) & 8'h01));
        total++;
        if (if0.abort !== 1'b0 || ab_cnt != 1 || ov_cnt != 0) begin
            $display("FAIL restart_pulse: abort=%b abort_count=%0d ov=%0d, want 0,1,0",
                     if0.abort, ab_cnt, ov_cnt);
        end else passed++;
        drive_bit(1'b1, 1'b0, 1'b0);
        total++;
        if (ov_cnt != 1 || if0.data_out !== 8'h5A || if0.parity_err !== 1'b0) begin
            $display("FAIL restart_word: ov=%0d data=%h pe=%b, want ov=1 data=5a pe=0",
                     ov_cnt, if0.data_out, if0.parity_err);
        end else passed++;
    endtask

    task automatic test_back_to_back();
        int first_ov;
        clear_counts();
        send_data(8'h12, 0, 0);
        drive_bit(1'b1, 1'b0, 1'b0);
        first_ov = last_ov_cyc;
        total++;
        if (ov_cnt != 1 || if0.data_out !== 8'h12 || if0.parity_err !== 1'b0) begin
            $display("FAIL b2b_first: ov=%0d data=%h pe=%b, want ov=1 data=12 pe=0",
                     ov_cnt, if0.data_out, if0.parity_err);
        end else passed++;
        send_data(8'h13, 0, 0);
        drive_bit(1'b1, 1'b0, 1'b1);
        total++;
        if (ov_cnt != 2 || (last_ov_cyc - first_ov) != 9 || if0.data_out !== 8'h13 ||
            if0.parity_err !== 1'b0 || ab_cnt != 0) begin
            $display("FAIL b2b_second: ov=%0d spacing=%0d data=%h pe=%b aborts=%0d, want 2 9 13 0 0",
                     ov_cnt, last_ov_cyc - first_ov, if0.data_out, if0.parity_err, ab_cnt);
        end else passed++;
    endtask

    task automatic test_reset_midframe();
        clear_counts();
        for (int i = 0; i < 5; i++) drive_bit(1'b1, (i == 0), 1'($urandom));
        @(negedge clk);
        if0.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        total++;
        if ({if0.data_out, if0.out_valid, if0.parity_err, if0.abort, if0.busy} !== 12'h000) begin
            $display("FAIL midreset_outputs: data=%h ov=%b pe=%b ab=%b busy=%b, want all 0",
                     if0.data_out, if0.out_valid, if0.parity_err, if0.abort, if0.busy);
        end else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) drive_bit(1'b1, 1'b0, 1'b1);
        total++;
        if (if0.busy !== 1'b0 || ov_cnt != 0 || ab_cnt != 0) begin
            $display("FAIL midreset_stray: busy=%b ov=%0d ab=%0d, want 0 0 0", if0.busy, ov_cnt, ab_cnt);
        end else passed++;
        send_data(8'hC3, 0, 0);
        drive_bit(1'b1, 1'b0, 1'b0);
        total++;
        if (ov_cnt != 1 || if0.data_out !== 8'hC3 || if0.parity_err !== 1'b0) begin
            $display("FAIL midreset_word: ov=%0d data=%h pe=%b, want ov=1 data=c3 pe=0",
                     ov_cnt, if0.data_out, if0.parity_err);
        end else passed++;
    endtask

    task automatic test_random();
        logic [7:0] w;
        bit         p;
        bit         part;
        int         nbits;
        for (int n = 0; n < 30; n++) begin
            w     = 8'($urandom);
            p     = 1'($urandom);
            part  = ($urandom_range(99) < 25);
            nbits = int'($urandom_range(8, 1));
            clear_counts();
            if (part) begin
                for (int i = 0; i < nbits; i++) drive_bit(1'b1, (i == 0), 1'($urandom));
            end
            send_data(w, 0, 30);
            drive_bit(1'b1, 1'b0, p);
            total++;
            if (ov_cnt != 1 || ov_cnt1 != 1 || if0.data_out !== w || if1.data_out !== w ||
                if0.busy !== 1'b0 || ab_cnt != int'(part)) begin
                $display("FAIL rand_word_%0d: ov=%0d/%0d data=%h/%h busy=%b ab=%0d, want 1/1 %h 0 %0d",
                         n, ov_cnt, ov_cnt1, if0.data_out, if1.data_out, if0.busy, ab_cnt, w, part);
            end else passed++;
            total++;
            if (if0.parity_err !== exp_err(w, p, 1'b0) || if1.parity_err !== exp_err(w, p, 1'b1)) begin
                $display("FAIL rand_parity_%0d: even=%b odd=%b, want even=%b odd=%b", n,
                         if0.parity_err, if1.parity_err, exp_err(w, p, 1'b0), exp_err(w, p, 1'b1));
            end else passed++;
            while ($urandom_range(99) < 40) drive_bit(1'b0, 1'b0, 1'($urandom));
        end
    endtask

    initial begin
        passed      = 0;
        total       = 0;
        cyc         = 0;
        last_ov_cyc = 0;
        clear_counts();
        test_reset();
        test_basic();
        test_gaps();
        test_restart();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
